alu_seq: RTL and testbench

Sequenced front-end for the 16-bit combinational `alu`: accepts operation requests over a valid/ready handshake, drives the ALU's operand and control inputs, and returns registered results and flags over a second valid/ready handshake. Adds a multi-cycle unsigned multiply built from N shift-and-add iterations through the same ALU adder. Sits between the datapath control unit (request side) and the result bus (response side).

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu.sv | 25 ++
 rtl/alu_seq.sv | 151 +++++++++++++++
 tb/tb_alu_seq.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequenced ALU front-end: opcodes, ALU control
// codes, FSM state encoding and the opcode-to-ALU-control mapping.
package alu_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_SHL = 3'b010;
    localparam logic [OP_W-1:0] OP_SHR = 3'b011;
    localparam logic [OP_W-1:0] OP_MUL = 3'b100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_SHR = 2'b01;
    localparam logic [1:0] ALU_SHL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EXEC   = 2'b01,
        ST_MUL_IT = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // Illegal opcodes drive the adder; their result is discarded anyway.
    function automatic logic [1:0] op_to_alu_ctrl(input logic [OP_W-1:0] op);
        logic [1:0] ctrl;
        ctrl = ALU_ADD;
        case (op)
            OP_SUB:  ctrl = ALU_SUB;
            OP_SHL:  ctrl = ALU_SHL;
            OP_SHR:  ctrl = ALU_SHR;
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of alu_seq. The master side issues requests and
// consumes responses; the slave side is the sequencer itself.
interface alu_seq_if #(parameter int N = 16);

    logic           i_valid;
    logic           o_ready;
    logic [2:0]     i_op;
    logic [N-1:0]   i_a;
    logic [N-1:0]   i_b;
    logic           o_valid;
    logic           i_ready;
    logic [2*N-1:0] o_q;
    logic           o_carry;
    logic           o_par;
    logic           o_err;

    modport master (
        output i_valid, i_op, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_q, o_carry, o_par, o_err
    );

    modport slave (
        input  i_valid, i_op, i_a, i_b, i_ready,
        output o_ready, o_valid, o_q, o_carry, o_par, o_err
    );

endinterface

// File: rtl/alu.sv
// Combinational 16-bit ALU: add, subtract, shift left, shift right by one.
// mayor is the adder carry-out (for subtract: the no-borrow bit).
module alu #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   ctrl,
    output logic [N-1:0] q,
    output logic         mayor
);

    // Select the operation and its carry-style side output.
    always_comb begin
        q     = '0;
        mayor = 1'b0;
        case (ctrl)
            2'b00: {mayor, q} = {1'b0, a} + {1'b0, b};
            2'b10: {mayor, q} = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
            2'b01: q = a >> 1;
            default: q = a << 1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequenced front-end for the combinational alu: valid/ready request in,
// registered result and flags out, plus an N-iteration shift-and-add multiply
// that reuses the ALU adder.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N = 16
) (
    input  logic    i_clk,
    input  logic    i_reset,
    alu_seq_if.slave bus
);

    localparam int CW = $clog2(N);

    state_t           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [N-1:0]     a_q, a_d;      // operand A / multiplicand
    logic [N-1:0]     b_q, b_d;      // operand B / multiplier, low accumulator half for MUL
    logic [N-1:0]     hi_q, hi_d;    // high accumulator half for MUL
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   res_q, res_d;
    logic             carry_q, carry_d;
    logic             par_q, par_d;
    logic             err_q, err_d;

    logic [N-1:0]     alu_a, alu_b, alu_q;
    logic [1:0]       alu_ctrl;
    logic             alu_mayor;
    logic [N:0]       mul_sum;

    alu #(.N(N)) u_alu (
        .a     (alu_a),
        .b     (alu_b),
        .ctrl  (alu_ctrl),
        .q     (alu_q),
        .mayor (alu_mayor)
    );

    // During multiply the ALU adds the multiplicand to the high half;
    // otherwise it sees the registered operands.
    always_comb begin
        alu_a    = a_q;
        alu_b    = b_q;
        alu_ctrl = op_to_alu_ctrl(op_q);
        if (state_q == ST_MUL_IT) begin
            alu_a    = hi_q;
            alu_b    = a_q;
            alu_ctrl = ALU_ADD;
        end
    end

    // Next-state, operand capture, multiply iteration and result formation.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        carry_d = carry_q;
        par_d   = par_q;
        err_d   = err_q;
        // {c,hi}: the carry bit only lives for one iteration, because the
        // right shift moves it into hi[N-1] immediately.
        mul_sum = b_q[0] ? {alu_mayor, alu_q} : {1'b0, hi_q};

        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    op_d    = bus.i_op;
                    a_d     = bus.i_a;
                    b_d     = bus.i_b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = (bus.i_op == OP_MUL) ? ST_MUL_IT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                res_d   = {{N{1'b0}}, alu_q};
                err_d   = 1'b0;
                case (op_q)
                    OP_ADD: carry_d = alu_mayor;
                    OP_SUB: carry_d = (a_q < b_q);
                    OP_SHL: carry_d = a_q[N-1];
                    OP_SHR: carry_d = a_q[0];
                    default: begin
                        res_d   = '0;
                        carry_d = 1'b0;
                        err_d   = 1'b1;
                    end
                endcase
                par_d = res_d[0];
            end
            ST_MUL_IT: begin
                hi_d  = mul_sum[N:1];
                b_d   = {mul_sum[0], b_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N-1)) begin
                    state_d = ST_DONE;
                    res_d   = {hi_d, b_d};
                    carry_d = |hi_d;
                    par_d   = b_d[0];
                    err_d   = 1'b0;
                end
            end
            default: begin
                if (bus.i_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            par_q   <= par_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_ready = (state_q == ST_IDLE) && !i_reset;
    assign bus.o_valid = (state_q == ST_DONE);
    assign bus.o_q     = res_q;
    assign bus.o_carry = carry_q;
    assign bus.o_par   = par_q;
    assign bus.o_err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with an expected-result queue fed at issue time.
module tb_alu_seq;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    typedef struct {
        logic [31:0] q;
        logic        c;
        logic        p;
        logic        e;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_seq_if #(.N(16)) bus();

    alu_seq #(.N(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t r;
        logic [16:0] s;
        logic [31:0] p;
        r.q = '0; r.c = 1'b0; r.e = 1'b0; r.lat = 1;
        case (op)
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r.q = {16'h0, s[15:0]}; r.c = s[16]; end
            3'b001: begin r.q = {16'h0, 16'(a - b)}; r.c = (a < b); end
            3'b010: begin r.q = {16'h0, 16'(a << 1)}; r.c = a[15]; end
            3'b011: begin r.q = {16'h0, 16'(a >> 1)}; r.c = a[0]; end
            3'b100: begin p = 32'(a) * 32'(b); r.q = p; r.c = (p[31:16] != 16'h0); r.lat = 16; end
            default: r.e = 1'b1;
        endcase
        r.p = r.q[0];
        return r;
    endfunction

    // Present one request at a falling edge and return 1ns after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        chk("ready_before_issue", 32'(bus.o_ready), 32'd1);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        $display("[TB] issue op=%0b a=0x%0h b=0x%0h", op, a, b);
    endtask

    // Wait for o_valid, then check latency and payload against the queue head.
    task automatic collect(input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        while (bus.o_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
        chk({tag, "_q"},     bus.o_q,            e.q);
        chk({tag, "_carry"}, 32'(bus.o_carry),   32'(e.c));
        chk({tag, "_par"},   32'(bus.o_par),     32'(e.p));
        chk({tag, "_err"},   32'(bus.o_err),     32'(e.e));
        $display("[TB] %s result q=0x%0h c=%0b p=%0b e=%0b lat=%0d", tag, bus.o_q, bus.o_carry, bus.o_par, bus.o_err, lat);
    endtask

    // Complete the response handshake and confirm return to IDLE.
    task automatic release_rsp(input string tag);
        @(negedge clk);
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        chk({tag, "_valid_after_hs"}, 32'(bus.o_valid), 32'd0);
        chk({tag, "_ready_after_hs"}, 32'(bus.o_ready), 32'd1);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [15:0] ra, rb;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_op    = '0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ready", 32'(bus.o_ready), 32'd1);
        chk("reset_valid", 32'(bus.o_valid), 32'd0);
        chk("reset_q",     bus.o_q,          32'd0);

        // Reset mid-cycle with a pending nonzero response.
        issue(3'b000, 16'h1234, 16'h1111);
        collect("pre_reset");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.o_valid), 32'd0);
        chk("async_rst_q",     bus.o_q,          32'd0);
        chk("async_rst_flags", {29'd0, bus.o_carry, bus.o_par, bus.o_err}, 32'd0);
        chk("async_rst_ready", 32'(bus.o_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.o_ready), 32'd1);

        issue(3'b000, 16'hFFFF, 16'h0001); collect("add");  release_rsp("add");
        issue(3'b001, 16'h0003, 16'h0005); collect("sub");  release_rsp("sub");
        issue(3'b010, 16'h8001, 16'h0000); collect("shl");  release_rsp("shl");
        issue(3'b011, 16'h8001, 16'h0000); collect("shr");  release_rsp("shr");

        issue(3'b100, 16'hFFFF, 16'hFFFF); collect("mul_max");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(bus.o_valid), 32'd1);
            chk("hold_ready", 32'(bus.o_ready), 32'd0);
            chk("hold_q",     bus.o_q,          32'hFFFE0001);
            chk("hold_carry", 32'(bus.o_carry), 32'd1);
        end
        release_rsp("mul_max");

        issue(3'b100, 16'h0003, 16'h0005); collect("mul_small"); release_rsp("mul_small");
        issue(3'b101, 16'h1234, 16'h5678); collect("illegal");   release_rsp("illegal");

        // Reset during the 7th multiply iteration.
        issue(3'b100, 16'h1234, 16'h00FF);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mul_abort_valid", 32'(bus.o_valid), 32'd0);
        chk("mul_abort_ready", 32'(bus.o_ready), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("mul_abort_no_valid", 32'(bus.o_valid), 32'd0);
        end
        issue(3'b000, 16'h0001, 16'h0002); collect("add_after_abort"); release_rsp("add_after_abort");

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            issue(rop, ra, rb);
            collect("rand");
            release_rsp("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
